// File: rtl/stream_sequencer.sv
// stream_sequencer: frame-rate controller for the I2S-to-SPDIF sample FIFO.
// Waits for PLL lock plus run request, settles for SETTLE_FRAMES frames,
// prefills the FIFO to PREFILL frames, then streams. Underrun, overrun, lock
// loss or run_req drop flush the FIFO and restart the sequence.
//
// Optional feature macro: STREAM_SEQ_STATS_EN adds saturating underrun/overrun
// counters (parameter CNT_W, ports underrun_cnt / overrun_cnt).
//
// Ports:
//   pin_i2s_fclk      frame clock (one edge per stereo frame)
//   rst               synchronous active-high reset
//   pll_lock          asynchronous PLL lock, synchronised internally
//   run_req           level request to stream
//   fifo_full/empty   FIFO status flags (same clock domain)
//   write_en/read_en  FIFO enables
//   fifo_flush        one-cycle flush pulse
//   validity          SPDIF sample-valid, high only while streaming
//   state             current state (IDLE=0 SETTLE=1 PREFILL=2 RUN=3 FLUSH=4)
//   occupancy         shadow FIFO fill count
//   led_red/green/blue active-low status LEDs
module stream_sequencer #(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned PREFILL       = 8,
   parameter int unsigned SETTLE_FRAMES = 4
`ifdef STREAM_SEQ_STATS_EN
   ,
   parameter int unsigned CNT_W         = 8
`endif
) (
   input  logic                         pin_i2s_fclk,
   input  logic                         rst,
   input  logic                         pll_lock,
   input  logic                         run_req,
   input  logic                         fifo_full,
   input  logic                         fifo_empty,
   output logic                         write_en,
   output logic                         read_en,
   output logic                         fifo_flush,
   output logic                         validity,
   output logic [2:0]                   state,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         led_red,
   output logic                         led_green,
   output logic                         led_blue
`ifdef STREAM_SEQ_STATS_EN
   ,
   output logic [CNT_W-1:0]             underrun_cnt,
   output logic [CNT_W-1:0]             overrun_cnt
`endif
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam int unsigned SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_PREFILL = 3'd2,
      S_RUN     = 3'd3,
      S_FLUSH   = 3'd4
   } state_t;

   state_t             cur_st;
   state_t             nxt_st;
   logic [1:0]         lock_sync;
   logic [SET_W-1:0]   settle_cnt;
   logic [OCC_W-1:0]   occ_nxt;
   logic               lock_s;
   logic               go;
   logic               wr_acc;
   logic               rd_acc;
   logic               und_det;
   logic               ovr_det;

   assign lock_s = lock_sync[1];
   assign state  = cur_st;

   // Next-state and shadow occupancy
   always_comb begin
      go      = lock_s && run_req;
      wr_acc  = write_en && !fifo_full;
      rd_acc  = read_en && !fifo_empty;
      und_det = (cur_st == S_RUN) && read_en && fifo_empty;
      ovr_det = (cur_st == S_RUN) && write_en && fifo_full;
      occ_nxt = occupancy;
      nxt_st  = cur_st;

      if (wr_acc && !rd_acc && (occupancy != OCC_W'(DEPTH)))
         occ_nxt = occupancy + OCC_W'(1);
      else if (rd_acc && !wr_acc && (occupancy != OCC_W'(0)))
         occ_nxt = occupancy - OCC_W'(1);

      // Abort (lost lock / dropped request) outranks every normal transition
      case (cur_st)
         S_IDLE:    if (go) nxt_st = S_SETTLE;
         S_SETTLE:  if (!go) nxt_st = S_FLUSH;
                    else if (settle_cnt == SET_W'(SETTLE_FRAMES - 1)) nxt_st = S_PREFILL;
         S_PREFILL: if (!go) nxt_st = S_FLUSH;
                    else if (occ_nxt == OCC_W'(PREFILL)) nxt_st = S_RUN;
         S_RUN:     if (!go || und_det || ovr_det) nxt_st = S_FLUSH;
         S_FLUSH:   nxt_st = go ? S_SETTLE : S_IDLE;
         default:   nxt_st = S_IDLE;
      endcase
   end

   // State register with outputs registered from the next state
   always_ff @(posedge pin_i2s_fclk) begin
      if (rst) begin
         lock_sync    <= 2'b00;
         cur_st       <= S_IDLE;
         settle_cnt   <= '0;
         write_en     <= 1'b0;
         read_en      <= 1'b0;
         fifo_flush   <= 1'b0;
         validity     <= 1'b0;
         occupancy    <= '0;
         led_red      <= 1'b0;
         led_green    <= 1'b1;
         led_blue     <= 1'b1;
`ifdef STREAM_SEQ_STATS_EN
         underrun_cnt <= '0;
         overrun_cnt  <= '0;
`endif
      end else begin
         lock_sync  <= {lock_sync[0], pll_lock};
         cur_st     <= nxt_st;
         settle_cnt <= (cur_st == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;
         write_en   <= (nxt_st == S_PREFILL) || (nxt_st == S_RUN);
         read_en    <= (nxt_st == S_RUN);
         validity   <= (nxt_st == S_RUN);
         fifo_flush <= (nxt_st == S_FLUSH);
         occupancy  <= (nxt_st == S_FLUSH) ? '0 : occ_nxt;
         led_red    <= !((nxt_st == S_IDLE) || (nxt_st == S_FLUSH));
         led_blue   <= !((nxt_st == S_SETTLE) || (nxt_st == S_PREFILL));
         led_green  <= !(nxt_st == S_RUN);
`ifdef STREAM_SEQ_STATS_EN
         if (und_det && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + CNT_W'(1);
         if (ovr_det && (overrun_cnt != '1))  overrun_cnt  <= overrun_cnt + CNT_W'(1);
`endif
      end
   end

endmodule
